// File: rtl/lc3_pkg.sv
// Shared LC3 pipeline-control types: opcodes, controller states, memory-state
// encodings and instruction-class decoders.
package lc3_pkg;

    typedef enum logic [3:0] {
        OP_BR  = 4'b0000,
        OP_ADD = 4'b0001,
        OP_LD  = 4'b0010,
        OP_ST  = 4'b0011,
        OP_AND = 4'b0101,
        OP_LDR = 4'b0110,
        OP_STR = 4'b0111,
        OP_NOT = 4'b1001,
        OP_LDI = 4'b1010,
        OP_STI = 4'b1011,
        OP_JMP = 4'b1100,
        OP_LEA = 4'b1110
    } op_t;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_MEM_IND = 2'd1,
        ST_MEM_ACC = 2'd2,
        ST_FLUSH   = 2'd3
    } ctrl_state_t;

    localparam logic [2:0] MS_LOAD  = 3'd0;
    localparam logic [2:0] MS_IND   = 3'd1;
    localparam logic [2:0] MS_STORE = 3'd2;
    localparam logic [2:0] MS_IDLE  = 3'd3;

    localparam logic [4:0] EN_NONE = 5'b00000;

    function automatic logic is_writer(input logic [15:0] ir);
        logic r;
        case (ir[15:12])
            OP_ADD, OP_AND, OP_NOT, OP_LD, OP_LDR, OP_LDI, OP_LEA: r = 1'b1;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic is_mem(input logic [15:0] ir);
        logic r;
        case (ir[15:12])
            OP_LD, OP_LDR, OP_LDI, OP_ST, OP_STR, OP_STI: r = 1'b1;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic is_ctrl(input logic [15:0] ir);
        logic r;
        case (ir[15:12])
            OP_BR, OP_JMP: r = 1'b1;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic is_store(input logic [15:0] ir);
        logic r;
        case (ir[15:12])
            OP_ST, OP_STR, OP_STI: r = 1'b1;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic is_indirect(input logic [15:0] ir);
        logic r;
        case (ir[15:12])
            OP_LDI, OP_STI: r = 1'b1;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic uses_src1(input logic [15:0] ir);
        logic r;
        case (ir[15:12])
            OP_ADD, OP_AND, OP_NOT, OP_STR: r = 1'b1;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    // Source 2 is the register operand of ADD/AND, or the store-data register.
    function automatic logic uses_src2(input logic [15:0] ir);
        logic r;
        case (ir[15:12])
            OP_ADD, OP_AND:        r = ~ir[5];
            OP_ST, OP_STI, OP_STR: r = 1'b1;
            default:               r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/lc3_pipe_ctrl_v2_if.sv
// Datapath <-> pipeline-controller bundle. The datapath is the master; the
// controller is the slave and drives enables, bypass selects and memory state.
interface lc3_pipe_ctrl_v2_if #(
    parameter int NUM_FWD = 2
);
    localparam int SEL_W = $clog2(NUM_FWD + 1);

    logic                    complete_data;
    logic                    complete_instr;
    logic [15:0]             IR;
    logic [15:0]             IR_Exec;
    logic [16*NUM_FWD-1:0]   IR_Fwd;
    logic [NUM_FWD-1:0]      Fwd_valid;
    logic [15:0]             IMem_dout;
    logic [2:0]              NZP;
    logic [2:0]              psr;

    logic                    enable_updatePC;
    logic                    enable_fetch;
    logic                    enable_decode;
    logic                    enable_execute;
    logic                    enable_writeback;
    logic                    br_taken;
    logic                    flush;
    logic [SEL_W-1:0]        fwd_sel_1;
    logic [SEL_W-1:0]        fwd_sel_2;
    logic [2:0]              mem_state;
    logic                    mem_err;

    modport master (
        output complete_data, complete_instr, IR, IR_Exec, IR_Fwd, Fwd_valid,
               IMem_dout, NZP, psr,
        input  enable_updatePC, enable_fetch, enable_decode, enable_execute,
               enable_writeback, br_taken, flush, fwd_sel_1, fwd_sel_2,
               mem_state, mem_err
    );

    modport slave (
        input  complete_data, complete_instr, IR, IR_Exec, IR_Fwd, Fwd_valid,
               IMem_dout, NZP, psr,
        output enable_updatePC, enable_fetch, enable_decode, enable_execute,
               enable_writeback, br_taken, flush, fwd_sel_1, fwd_sel_2,
               mem_state, mem_err
    );

endinterface

// File: rtl/lc3_fwd_select.sv
// Priority bypass match for one source operand: the youngest live writer whose
// destination equals the source wins; select 0 means register file.
module lc3_fwd_select #(
    parameter int NUM_FWD = 2,
    parameter int REG_AW  = 3,
    parameter int SEL_W   = $clog2(NUM_FWD + 1)
) (
    input  logic                      src_used,
    input  logic [REG_AW-1:0]         src,
    input  logic [NUM_FWD-1:0]        stage_live,
    input  logic [NUM_FWD*REG_AW-1:0] stage_dest,
    output logic [SEL_W-1:0]          sel
);

    // Walk oldest to youngest so the lowest matching stage overrides.
    always_comb begin
        sel = '0;
        for (int k = NUM_FWD - 1; k >= 0; k--) begin
            sel = (src_used && stage_live[k] &&
                   (stage_dest[k*REG_AW +: REG_AW] == src)) ? SEL_W'(k + 1) : sel;
        end
    end

endmodule

// File: rtl/lc3_pipe_ctrl_v2.sv
// LC3 pipeline controller: stage enables, multi-stage operand forwarding,
// branch flush window, LDI/STI memory sequencing and a memory watchdog.
module lc3_pipe_ctrl_v2 #(
    parameter int NUM_FWD     = 2,
    parameter int REG_AW      = 3,
    parameter int FLUSH_DEPTH = 2,
    parameter int MEM_TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst,
    lc3_pipe_ctrl_v2_if.slave bus
);
    import lc3_pkg::*;

    localparam int SEL_W   = $clog2(NUM_FWD + 1);
    localparam int CNT_MAX = (MEM_TIMEOUT > FLUSH_DEPTH) ? MEM_TIMEOUT : FLUSH_DEPTH;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(MEM_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] FL_LAST = CNT_W'(FLUSH_DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    ctrl_state_t              state_r;
    logic [CNT_W-1:0]         cnt_r;
    logic                     store_r;
    logic                     done_r;
    logic                     hold_r;
    logic [4:0]               en_r;
    logic                     br_taken_r;
    logic                     flush_r;
    logic                     mem_err_r;
    logic [2:0]               mem_state_r;
    logic [SEL_W-1:0]         sel1_r;
    logic [SEL_W-1:0]         sel2_r;

    logic [NUM_FWD-1:0]        live_s;
    logic [NUM_FWD*REG_AW-1:0] dest_s;
    logic                      src1_used_s;
    logic                      src2_used_s;
    logic [REG_AW-1:0]         src2_s;
    logic [SEL_W-1:0]          sel1_s;
    logic [SEL_W-1:0]          sel2_s;
    logic                      taken_s;
    logic                      hold_s;
    logic [4:0]                en_run_s;
    logic [4:0]                en_flush_s;

    // Per-stage forwarding candidates: live writer flag and destination register.
    always_comb begin
        live_s = '0;
        dest_s = '0;
        for (int k = 0; k < NUM_FWD; k++) begin
            live_s[k] = bus.Fwd_valid[k] & is_writer(bus.IR_Fwd[k*16 +: 16]);
            dest_s[k*REG_AW +: REG_AW] = bus.IR_Fwd[k*16+9 +: REG_AW];
        end
    end

    assign src1_used_s = uses_src1(bus.IR);
    assign src2_used_s = uses_src2(bus.IR);
    assign src2_s      = is_store(bus.IR) ? bus.IR[9 +: REG_AW] : bus.IR[0 +: REG_AW];

    lc3_fwd_select #(.NUM_FWD(NUM_FWD), .REG_AW(REG_AW), .SEL_W(SEL_W)) u_fwd_src1 (
        .src_used   (src1_used_s),
        .src        (bus.IR[6 +: REG_AW]),
        .stage_live (live_s),
        .stage_dest (dest_s),
        .sel        (sel1_s)
    );

    lc3_fwd_select #(.NUM_FWD(NUM_FWD), .REG_AW(REG_AW), .SEL_W(SEL_W)) u_fwd_src2 (
        .src_used   (src2_used_s),
        .src        (src2_s),
        .stage_live (live_s),
        .stage_dest (dest_s),
        .sel        (sel2_s)
    );

    assign taken_s = ((bus.IR_Exec[15:12] == OP_BR) && (|(bus.NZP & bus.psr))) ||
                     (bus.IR_Exec[15:12] == OP_JMP);

    // Fetch hold: set when a BR/JMP is fetched, released once a branch resolves in execute.
    always_comb begin
        hold_s = hold_r;
        if ((state_r == ST_RUN) && is_ctrl(bus.IR_Exec)) begin
            hold_s = 1'b0;
        end else if (!hold_r && bus.complete_instr && is_ctrl(bus.IMem_dout)) begin
            hold_s = 1'b1;
        end else begin
            hold_s = hold_r;
        end
    end

    // Enable vectors ordered {updatePC, fetch, decode, execute, writeback}.
    assign en_run_s   = {~hold_s, ~hold_s & bus.complete_instr, 1'b1, 1'b1, 1'b1};
    assign en_flush_s = {1'b1, bus.complete_instr, 1'b0, 1'b0, 1'b1};

    // Controller FSM with registered enables, branch pulses, memory state and watchdog.
    // done_r keeps the just-finished memory op, still sitting in execute, from restarting.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r     <= ST_RUN;
            cnt_r       <= '0;
            store_r     <= 1'b0;
            done_r      <= 1'b0;
            hold_r      <= 1'b0;
            en_r        <= EN_NONE;
            br_taken_r  <= 1'b0;
            flush_r     <= 1'b0;
            mem_err_r   <= 1'b0;
            mem_state_r <= MS_IDLE;
        end else begin
            hold_r     <= hold_s;
            br_taken_r <= 1'b0;
            flush_r    <= 1'b0;
            mem_err_r  <= 1'b0;
            done_r     <= 1'b0;
            case (state_r)
                ST_RUN: begin
                    if (is_mem(bus.IR_Exec) && !done_r) begin
                        state_r     <= is_indirect(bus.IR_Exec) ? ST_MEM_IND : ST_MEM_ACC;
                        cnt_r       <= '0;
                        store_r     <= is_store(bus.IR_Exec);
                        en_r        <= EN_NONE;
                        mem_state_r <= is_indirect(bus.IR_Exec) ? MS_IND :
                                       (is_store(bus.IR_Exec) ? MS_STORE : MS_LOAD);
                    end else if (taken_s) begin
                        state_r     <= ST_FLUSH;
                        cnt_r       <= '0;
                        en_r        <= en_flush_s;
                        br_taken_r  <= 1'b1;
                        flush_r     <= 1'b1;
                        mem_state_r <= MS_IDLE;
                    end else begin
                        en_r        <= en_run_s;
                        mem_state_r <= MS_IDLE;
                    end
                end
                ST_MEM_IND, ST_MEM_ACC: begin
                    if ((cnt_r == WD_LAST) && !bus.complete_data) begin
                        state_r     <= ST_RUN;
                        mem_err_r   <= 1'b1;
                        done_r      <= 1'b1;
                        en_r        <= EN_NONE;
                        mem_state_r <= MS_IDLE;
                    end else if (bus.complete_data && (state_r == ST_MEM_IND)) begin
                        state_r     <= ST_MEM_ACC;
                        cnt_r       <= '0;
                        en_r        <= EN_NONE;
                        mem_state_r <= store_r ? MS_STORE : MS_LOAD;
                    end else if (bus.complete_data) begin
                        state_r     <= ST_RUN;
                        done_r      <= 1'b1;
                        en_r        <= en_run_s;
                        mem_state_r <= MS_IDLE;
                    end else begin
                        cnt_r       <= cnt_r + CNT_ONE;
                        en_r        <= EN_NONE;
                        mem_state_r <= mem_state_r;
                    end
                end
                ST_FLUSH: begin
                    if (cnt_r == FL_LAST) begin
                        state_r <= ST_RUN;
                        en_r    <= en_run_s;
                    end else begin
                        cnt_r   <= cnt_r + CNT_ONE;
                        en_r    <= en_flush_s;
                    end
                    mem_state_r <= MS_IDLE;
                end
                default: begin
                    state_r     <= ST_RUN;
                    cnt_r       <= '0;
                    en_r        <= EN_NONE;
                    mem_state_r <= MS_IDLE;
                end
            endcase
        end
    end

    // Registered bypass selects.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sel1_r <= '0;
            sel2_r <= '0;
        end else begin
            sel1_r <= sel1_s;
            sel2_r <= sel2_s;
        end
    end

    assign bus.enable_updatePC  = en_r[4];
    assign bus.enable_fetch     = en_r[3];
    assign bus.enable_decode    = en_r[2];
    assign bus.enable_execute   = en_r[1];
    assign bus.enable_writeback = en_r[0];
    assign bus.br_taken         = br_taken_r;
    assign bus.flush            = flush_r;
    assign bus.fwd_sel_1        = sel1_r;
    assign bus.fwd_sel_2        = sel2_r;
    assign bus.mem_state        = mem_state_r;
    assign bus.mem_err          = mem_err_r;

endmodule

// File: tb/tb_lc3_pipe_ctrl_v2.sv
// Directed bench for lc3_pipe_ctrl_v2: reset, forwarding, LDI sequencing,
// branch flush, fetch hold, watchdog and mid-access reset.
module tb_lc3_pipe_ctrl_v2;
    import lc3_pkg::*;

    localparam logic [15:0] NOP = 16'h1000;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    logic [4:0] en_obs;

    lc3_pipe_ctrl_v2_if #(.NUM_FWD(2)) bus ();

    lc3_pipe_ctrl_v2 #(
        .NUM_FWD(2), .REG_AW(3), .FLUSH_DEPTH(2), .MEM_TIMEOUT(64)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    assign en_obs = {bus.enable_updatePC, bus.enable_fetch, bus.enable_decode,
                     bus.enable_execute, bus.enable_writeback};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        bus.complete_data  = 1'b0;
        bus.complete_instr = 1'b1;
        bus.IR             = NOP;
        bus.IR_Exec        = NOP;
        bus.IR_Fwd         = {NOP, NOP};
        bus.Fwd_valid      = 2'b00;
        bus.IMem_dout      = NOP;
        bus.NZP            = 3'b000;
        bus.psr            = 3'b010;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b0;
        idle();

        // Reset held with LDI in execute
        bus.IR_Exec = 16'hA000;
        repeat (3) step();
        chk("rst_mem_state", 16'(bus.mem_state), 16'd3);
        chk("rst_enables",   16'(en_obs), 16'h0000);
        chk("rst_flags",     16'({bus.br_taken, bus.flush, bus.mem_err}), 16'h0000);
        chk("rst_fwd",       16'({bus.fwd_sel_1, bus.fwd_sel_2}), 16'h0000);
        chk("rst_state_run", 16'(dut.state_r), 16'(ST_RUN));
        rst = 1'b1;
        bus.IR_Exec = NOP;
        step();
        chk("run_enables",   16'(en_obs), 16'h001F);
        chk("run_mem_state", 16'(bus.mem_state), 16'd3);

        // Forwarding: ADD R1,R2,R3; stage0 ADD R2, stage1 LD R3
        bus.IR = 16'h1283; bus.IR_Exec = 16'h1400;
        bus.IR_Fwd = {16'h2600, 16'h1400}; bus.Fwd_valid = 2'b11;
        step();
        chk("fwdA_sel1", 16'(bus.fwd_sel_1), 16'd1);
        chk("fwdA_sel2", 16'(bus.fwd_sel_2), 16'd2);
        bus.IR_Fwd = {16'h2400, 16'h1400}; bus.Fwd_valid = 2'b10;
        step();
        chk("fwdB_sel1", 16'(bus.fwd_sel_1), 16'd2);
        chk("fwdB_sel2", 16'(bus.fwd_sel_2), 16'd0);
        bus.Fwd_valid = 2'b11;
        step();
        chk("fwd_youngest", 16'(bus.fwd_sel_1), 16'd1);
        bus.IR_Exec = NOP; bus.IR_Fwd = {NOP, 16'h3400}; bus.Fwd_valid = 2'b01;
        step();
        chk("fwd_nonwriter", 16'({bus.fwd_sel_1, bus.fwd_sel_2}), 16'h0000);
        bus.IR = 16'h7A00; bus.IR_Exec = 16'h5A00;
        bus.IR_Fwd = {NOP, 16'h5A00}; bus.Fwd_valid = 2'b01;
        step();
        chk("fwd_str_sel2", 16'(bus.fwd_sel_2), 16'd1);
        chk("fwd_str_sel1", 16'(bus.fwd_sel_1), 16'd0);
        bus.IR = 16'h12A3; bus.IR_Exec = 16'h1600; bus.IR_Fwd = {NOP, 16'h1600};
        step();
        chk("fwd_imm_sel2", 16'(bus.fwd_sel_2), 16'd0);
        bus.IR = 16'h1283;
        step();
        chk("fwd_reg_sel2", 16'(bus.fwd_sel_2), 16'd1);
        idle();
        step();

        // Indirect load: completions sampled at +4 and +7
        bus.IR_Exec = 16'hA000;
        step();
        chk("ldi_ms0", 16'(bus.mem_state), 16'd1);
        chk("ldi_en0", 16'(en_obs), 16'h0000);
        repeat (3) step();
        chk("ldi_ms3", 16'(bus.mem_state), 16'd1);
        bus.complete_data = 1'b1;
        step();
        bus.complete_data = 1'b0;
        chk("ldi_ms4", 16'(bus.mem_state), 16'd0);
        repeat (2) step();
        chk("ldi_ms6", 16'(bus.mem_state), 16'd0);
        chk("ldi_en6", 16'(en_obs), 16'h0000);
        bus.complete_data = 1'b1;
        step();
        bus.complete_data = 1'b0;
        chk("ldi_ms7", 16'(bus.mem_state), 16'd3);
        chk("ldi_wb7", 16'(en_obs), 16'h001F);
        bus.IR_Exec = NOP;
        step();
        chk("ldi_ms8", 16'(bus.mem_state), 16'd3);

        // complete_data while running is ignored
        bus.complete_data = 1'b1;
        step();
        bus.complete_data = 1'b0;
        chk("cd_run_ms", 16'(bus.mem_state), 16'd3);
        chk("cd_run_en", 16'(en_obs), 16'h001F);

        // Taken BR n with psr=n
        bus.IR_Exec = 16'h0800; bus.NZP = 3'b100; bus.psr = 3'b100;
        step();
        chk("br_flags0", 16'({bus.br_taken, bus.flush}), 16'h0003);
        chk("br_en0",    16'(en_obs), 16'h0019);
        bus.IR_Exec = NOP;
        step();
        chk("br_flags1", 16'({bus.br_taken, bus.flush}), 16'h0000);
        chk("br_en1",    16'(en_obs), 16'h0019);
        step();
        chk("br_en2",    16'(en_obs), 16'h001F);
        // Same BR with psr=z: not taken
        bus.IR_Exec = 16'h0800; bus.psr = 3'b010;
        step();
        chk("brn_flags", 16'({bus.br_taken, bus.flush}), 16'h0000);
        chk("brn_en",    16'(en_obs), 16'h001F);
        bus.IR_Exec = 16'hC1C0;
        step();
        chk("jmp_flags", 16'({bus.br_taken, bus.flush}), 16'h0003);
        bus.IR_Exec = NOP;
        repeat (2) step();
        chk("jmp_en",    16'(en_obs), 16'h001F);

        // Fetch hold on fetched BR until a branch resolves
        bus.IMem_dout = 16'h0800;
        step();
        chk("hold_en0", 16'(en_obs), 16'h0007);
        bus.IMem_dout = NOP;
        step();
        chk("hold_en1", 16'(en_obs), 16'h0007);
        bus.IR_Exec = 16'h0800;
        step();
        chk("hold_en2", 16'(en_obs), 16'h001F);
        bus.IR_Exec = NOP; bus.complete_instr = 1'b0;
        step();
        chk("no_instr_en", 16'(en_obs), 16'h0017);
        bus.complete_instr = 1'b1;

        // Watchdog on ST with no completion
        bus.IR_Exec = 16'h3000;
        step();
        chk("wd_ms0", 16'(bus.mem_state), 16'd2);
        repeat (63) step();
        chk("wd_err63", 16'(bus.mem_err), 16'd0);
        chk("wd_ms63",  16'(bus.mem_state), 16'd2);
        step();
        chk("wd_err64", 16'(bus.mem_err), 16'd1);
        chk("wd_ms64",  16'(bus.mem_state), 16'd3);
        bus.IR_Exec = NOP;
        step();
        chk("wd_err65", 16'(bus.mem_err), 16'd0);
        chk("wd_en65",  16'(en_obs), 16'h001F);
        chk("wd_state", 16'(dut.state_r), 16'(ST_RUN));

        // Reset in the middle of a load abandons it
        bus.IR_Exec = 16'h2000;
        step();
        chk("ld_ms", 16'(bus.mem_state), 16'd0);
        rst = 1'b0;
        step();
        rst = 1'b1;
        chk("rstmid_ms",  16'(bus.mem_state), 16'd3);
        chk("rstmid_en",  16'(en_obs), 16'h0000);
        chk("rstmid_err", 16'(bus.mem_err), 16'd0);
        bus.IR_Exec = NOP;
        step();
        chk("post_rst_en", 16'(en_obs), 16'h001F);
        chk("post_rst_ms", 16'(bus.mem_state), 16'd3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
